aes_wb_queue: RTL and testbench

- Wishbone slave that front-ends a block-cipher core. It is the next-generation AES bus wrapper.
- Adds:
  - parametrised key width;
  - a DEPTH-entry plaintext input queue;
  - a DEPTH-entry ciphertext output queue;
  - a sequencing FSM that feeds the core one block at a time;
  - status/interrupt reporting.
- Sits between the system Wishbone fabric and an external cipher core connected through the core_* ports.

---
 rtl/aes_wb_queue_if.sv | 25 ++
 rtl/aes_wb_queue.sv | 224 ++++++++++++++++++++++
 tb/tb_aes_wb_queue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_wb_queue_if.sv
// Wishbone slave-side bus bundle for aes_wb_queue.
interface aes_wb_queue_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [AW-1:0] wb_adr_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;

  modport slave (
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/aes_wb_queue.sv
// Wishbone front-end for an external block-cipher core: plaintext and
// ciphertext queues, a sequencing FSM and status/interrupt reporting.
// Optional watchdog on the core: define AES_WB_TIMEOUT_EN.
module aes_wb_queue #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned KEY_W       = 192,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  aes_wb_queue_if.slave      wb,
  output logic               int_o,
  output logic               core_start,
  output logic [127:0]       core_state,
  output logic [KEY_W-1:0]   core_key,
  input  logic [127:0]       core_out,
  input  logic               core_valid
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned NKW = KEY_W / 32;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_t;
  state_t r_state, w_state_nx;

  logic r_ack, r_err, r_int, r_irq_en, r_ovf, r_done, r_tmo, r_discard, r_start;
  logic [DW-1:0]    r_dat, w_rdata;
  logic [127:0]     r_pt, r_core_state, r_result, w_out_head;
  logic [KEY_W-1:0] r_key, r_core_key;
  logic [127:0]     r_inq  [DEPTH];
  logic [127:0]     r_outq [DEPTH];
  logic [PW-1:0]    r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CW-1:0]    r_in_cnt, r_out_cnt;

  logic [4:0] w_addr;
  logic w_acc, w_wr, w_rd, w_ctrl_wr, w_go, w_flush, w_stat_wr, w_in_full;
  logic w_in_push, w_in_pop, w_out_push, w_out_pop, w_ovf_set, w_tmo_hit, w_unused;

  assign w_addr     = wb.wb_adr_i[4:0];
  assign w_acc      = wb.wb_cyc_i & wb.wb_stb_i & ~(r_ack | r_err);
  assign w_wr       = w_acc & wb.wb_we_i;
  assign w_rd       = w_acc & ~wb.wb_we_i;
  assign w_ctrl_wr  = w_wr & (w_addr == 5'd0);
  assign w_go       = w_ctrl_wr & wb.wb_dat_i[0];
  assign w_flush    = w_ctrl_wr & wb.wb_dat_i[1];
  assign w_stat_wr  = w_wr & (w_addr == 5'd1);
  assign w_in_full  = (r_in_cnt == CW'(DEPTH));
  assign w_in_pop   = (r_state == StIssue);
  // FLUSH wins over a GO in the same write; a slot freed by ISSUE is reusable.
  assign w_in_push  = w_go & ~w_flush & (~w_in_full | w_in_pop);
  assign w_ovf_set  = w_go & ~w_flush & w_in_full & ~w_in_pop;
  assign w_out_push = (r_state == StWrite) & ~w_flush;
  assign w_out_pop  = w_rd & (w_addr == 5'd17) & (r_out_cnt != '0);
  assign w_out_head = r_outq[r_out_rp];

`ifdef AES_WB_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  assign w_tmo_hit = (r_state == StWait) & ~core_valid & (r_tmo_cnt == TIMEOUT_CYC - 1);
  assign w_unused  = ^{wb.wb_sel_i, wb.wb_adr_i[AW-1:5]};

  // Watchdog counts cycles spent waiting on the core.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                r_tmo_cnt <= '0;
    else if (r_state != StWait)  r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + 32'd1;
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_unused  = ^{wb.wb_sel_i, wb.wb_adr_i[AW-1:5], 1'(TIMEOUT_CYC & 1)};
`endif

  // Next-state logic for the block sequencer.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle:  if (r_in_cnt != '0 && !w_flush && r_out_cnt < CW'(DEPTH)) w_state_nx = StIssue;
      StIssue: w_state_nx = StWait;
      StWait: begin
        if (core_valid)     w_state_nx = (r_discard | w_flush) ? StIdle : StWrite;
        else if (w_tmo_hit) w_state_nx = StIdle;
      end
      StWrite: w_state_nx = StIdle;
      default: w_state_nx = StIdle;
    endcase
  end

  // FSM state, core handshake registers and discard tracking.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= StIdle;
      r_start      <= 1'b0;
      r_core_state <= '0;
      r_core_key   <= '0;
      r_result     <= '0;
      r_discard    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_start <= (r_state == StIssue);
      if (r_state == StIssue) begin
        r_core_state <= r_inq[r_in_rp];
        r_core_key   <= r_key;
      end
      if (r_state == StWait && core_valid) r_result <= core_out;
      // Any core_valid consumes a pending discard, including a late one.
      if (core_valid) r_discard <= 1'b0;
      else if ((w_flush && (r_state == StIssue || r_state == StWait)) || w_tmo_hit)
        r_discard <= 1'b1;
    end
  end

  // Plaintext input queue.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_inq[i] <= '0;
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else if (w_flush) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_inq[r_in_wp] <= r_pt;
        r_in_wp        <= r_in_wp + PW'(1);
      end
      if (w_in_pop) r_in_rp <= r_in_rp + PW'(1);
      r_in_cnt <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
    end
  end

  // Ciphertext output queue; bus pop and FSM push may coincide.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_outq[i] <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else if (w_flush) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) begin
        r_outq[r_out_wp] <= r_result;
        r_out_wp         <= r_out_wp + PW'(1);
      end
      if (w_out_pop) r_out_rp <= r_out_rp + PW'(1);
      r_out_cnt <= r_out_cnt + CW'(w_out_push) - CW'(w_out_pop);
    end
  end

  // Software-visible registers and sticky status (set beats W1C).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq_en <= 1'b0;
      r_pt     <= '0;
      r_key    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= wb.wb_dat_i[2];
      for (int k = 0; k < 4; k++)
        if (w_wr && w_addr == 5'(2 + k)) r_pt[127 - 32*k -: 32] <= wb.wb_dat_i[31:0];
      for (int k = 0; k < int'(NKW); k++)
        if (w_wr && w_addr == 5'(6 + k)) r_key[KEY_W - 1 - 32*k -: 32] <= wb.wb_dat_i[31:0];
      if (w_stat_wr && wb.wb_dat_i[3]) r_ovf  <= 1'b0;
      if (w_stat_wr && wb.wb_dat_i[4]) r_done <= 1'b0;
      if (w_stat_wr && wb.wb_dat_i[5]) r_tmo  <= 1'b0;
      if (w_ovf_set)             r_ovf  <= 1'b1;
      if (r_state == StWrite)    r_done <= 1'b1;
      if (w_tmo_hit)             r_tmo  <= 1'b1;
      r_int <= r_irq_en & (r_done | r_ovf | r_tmo);
    end
  end

  // Read-data decode.
  always_comb begin
    w_rdata = '0;
    if (w_addr == 5'd0) begin
      w_rdata[2] = r_irq_en;
    end else if (w_addr == 5'd1) begin
      w_rdata[0]     = (r_state != StIdle);
      w_rdata[1]     = w_in_full;
      w_rdata[2]     = (r_out_cnt != '0);
      w_rdata[3]     = r_ovf;
      w_rdata[4]     = r_done;
      w_rdata[5]     = r_tmo;
      w_rdata[12:8]  = 5'(r_in_cnt);
      w_rdata[20:16] = 5'(r_out_cnt);
    end
    for (int k = 0; k < 4; k++)
      if (w_addr == 5'(2 + k)) w_rdata[31:0] = r_pt[127 - 32*k -: 32];
    for (int k = 0; k < int'(NKW); k++)
      if (w_addr == 5'(6 + k)) w_rdata[31:0] = r_key[KEY_W - 1 - 32*k -: 32];
    for (int k = 0; k < 4; k++)
      if (w_addr == 5'(14 + k) && r_out_cnt != '0) w_rdata[31:0] = w_out_head[127 - 32*k -: 32];
  end

  // Bus response: ack for the register window, err above it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc & (w_addr < 5'd18);
      r_err <= w_acc & (w_addr >= 5'd18);
      r_dat <= (w_rd && w_addr < 5'd18) ? w_rdata : '0;
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign int_o       = r_int;
  assign core_start  = r_start;
  assign core_state  = r_core_state;
  assign core_key    = r_core_key;
endmodule

// File: tb/tb_aes_wb_queue.sv
// Directed bench for aes_wb_queue with a 12-cycle XOR core model.
module tb_aes_wb_queue;
  localparam int unsigned KEY_W = 192;
  localparam logic [127:0] PT0     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_LO  = 128'h08090a0b_0c0d0e0f_10111213_14151617;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic int_o, core_start, core_valid;
  logic [127:0] core_state, core_out;
  logic [KEY_W-1:0] core_key;
  logic stall = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_start = 0;

  aes_wb_queue_if #(.DW(32), .AW(32)) bus ();

  aes_wb_queue #(
    .DW(32), .AW(32), .KEY_W(KEY_W), .DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (bus),
    .int_o      (int_o),
    .core_start (core_start),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .core_valid (core_valid)
  );

  always #5 clk = ~clk;

  // Core model: result = state ^ key[127:0], 12 cycles after start unless stalled.
  logic m_pend;
  int m_cnt;
  logic [127:0] m_lat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0; m_cnt <= 0; m_lat <= '0; core_valid <= 1'b0; core_out <= '0;
    end else begin
      core_valid <= 1'b0;
      if (core_start) begin
        m_pend <= 1'b1; m_cnt <= 12; m_lat <= core_state ^ core_key[127:0];
      end else if (m_pend && !stall) begin
        if (m_cnt <= 1) begin
          core_valid <= 1'b1; core_out <= m_lat; m_pend <= 1'b0;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (core_start) n_start <= n_start + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wb_xfer(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ack, output logic err);
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = {27'b0, a}; bus.wb_dat_i = wd; bus.wb_sel_i = 4'hf;
    rd = '0; ack = 1'b0; err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.wb_ack_o || bus.wb_err_o) begin
        ack = bus.wb_ack_o; err = bus.wb_err_o; rd = bus.wb_dat_o;
        break;
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ack, err;
    wb_xfer(1'b1, a, d, rd, ack, err);
  endtask

  task automatic wb_rd(input logic [4:0] a, output logic [31:0] d);
    logic ack, err;
    wb_xfer(1'b0, a, 32'h0, d, ack, err);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll STATUS until (st & mask) != 0; returns last STATUS and whether it hit.
  task automatic poll_status(input logic [31:0] mask, input int limit,
                             output logic [31:0] st, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      wb_rd(5'd1, st);
      if ((st & mask) != 0) begin hit = 1'b1; break; end
    end
  endtask

  task automatic read_block(output logic [127:0] blk);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      wb_rd(5'(14 + k), w);
      blk[127 - 32*k -: 32] = w;
    end
  endtask

  task automatic test_reset;
    logic [31:0] st;
    rst = 1'b1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    wait_cyc(3);
    checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", bus.wb_ack_o); end
    checks++; if (bus.wb_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.wb_err_o); end
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b want=0", core_start); end
    checks++; if (core_state !== '0) begin failures++; $display("FAIL reset_state got=%h want=0", core_state); end
    rst = 1'b0;
    wait_cyc(2);
    wb_rd(5'd1, st);
    checks++; if (st !== 32'h0) begin failures++; $display("FAIL reset_status got=%h want=0", st); end
    wb_rd(5'd0, st);
    checks++; if (st !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h want=0", st); end
  endtask

  task automatic test_single;
    logic [31:0] st, w; logic hit, ack, err; int base;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h08182838; exp_w[1] = 32'h48586878;
    exp_w[2] = 32'h9888b8a8; exp_w[3] = 32'hd8c8f8e8;
    for (int i = 0; i < 6; i++)
      wb_wr(5'(6 + i), {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
    for (int k = 0; k < 4; k++) wb_wr(5'(2 + k), PT0[127 - 32*k -: 32]);
    base = n_start;
    wb_wr(5'd0, 32'h1);
    poll_status(32'h10, 60, st, hit);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL single_done got=%h want bit4", st); end
    checks++; if (n_start - base != 1) begin failures++; $display("FAIL single_starts got=%0d want=1", n_start - base); end
    checks++; if (st[20:16] !== 5'd1) begin failures++; $display("FAIL single_outcnt got=%0d want=1", st[20:16]); end
    checks++; if (st[0] !== 1'b0) begin failures++; $display("FAIL single_busy got=%b want=0", st[0]); end
    for (int k = 0; k < 4; k++) begin
      wb_rd(5'(14 + k), w);
      checks++; if (w !== exp_w[k]) begin failures++; $display("FAIL single_ct%0d got=%h want=%h", k, w, exp_w[k]); end
    end
    wb_rd(5'd1, st);
    checks++; if (st[20:16] !== 5'd0) begin failures++; $display("FAIL single_pop got=%0d want=0", st[20:16]); end
    wb_rd(5'd14, w);
    checks++; if (w !== 32'h0) begin failures++; $display("FAIL empty_read got=%h want=0", w); end
    wb_xfer(1'b0, 5'd13, 32'h0, w, ack, err);
    checks++; if (ack !== 1'b1 || w !== 32'h0) begin failures++; $display("FAIL key_unimpl ack=%b data=%h want ack=1 data=0", ack, w); end
    wb_xfer(1'b0, 5'd20, 32'h0, w, ack, err);
    checks++; if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL addr20 err=%b ack=%b want err=1 ack=0", err, ack); end
    wb_wr(5'd0, 32'h4);
    wait_cyc(2);
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL irq_done got=%b want=1", int_o); end
    wb_rd(5'd0, w);
    checks++; if (w !== 32'h4) begin failures++; $display("FAIL ctrl_read got=%h want=4", w); end
    wb_wr(5'd1, 32'h10);
    wait_cyc(2);
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b want=0", int_o); end
    wb_wr(5'd0, 32'h0);
  endtask

  task automatic test_queue_full;
    logic [31:0] st; logic hit; logic [127:0] blk, exp;
    stall = 1'b1;
    wb_wr(5'd1, 32'h38);
    for (int b = 0; b < 6; b++) begin
      wb_wr(5'd5, 32'h100 + 32'(b));
      wb_wr(5'd0, 32'h1);
    end
    wb_rd(5'd1, st);
    checks++; if (st[12:8] !== 5'd4 || st[1] !== 1'b1) begin failures++; $display("FAIL qfull_in got=%h want in_count=4 full=1", st); end
    checks++; if (st[3] !== 1'b1 || st[0] !== 1'b1) begin failures++; $display("FAIL qfull_ovf got=%h want ovf=1 busy=1", st); end
    stall = 1'b0;
    for (int b = 0; b < 5; b++) begin
      poll_status(32'h4, 100, st, hit);
      exp = {PT0[127:32], 32'h100 + 32'(b)} ^ KEY_LO;
      read_block(blk);
      checks++; if (hit !== 1'b1 || blk !== exp) begin failures++; $display("FAIL qfull_blk%0d got=%h want=%h", b, blk, exp); end
    end
    wb_rd(5'd1, st);
    checks++; if (st[3] !== 1'b1 || st[12:8] !== 5'd0 || st[20:16] !== 5'd0) begin failures++; $display("FAIL qfull_after got=%h want ovf=1 counts=0", st); end
    wb_wr(5'd1, 32'h8);
    wb_rd(5'd1, st);
    checks++; if (st[3] !== 1'b0) begin failures++; $display("FAIL ovf_w1c got=%b want=0", st[3]); end
  endtask

  task automatic test_flush;
    logic [31:0] st; int base;
    wb_wr(5'd1, 32'h38);
    stall = 1'b1;
    base = n_start;
    wb_wr(5'd0, 32'h1);
    wb_wr(5'd0, 32'h1);
    wb_rd(5'd1, st);
    checks++; if (st[0] !== 1'b1 || st[12:8] !== 5'd1) begin failures++; $display("FAIL flush_pre got=%h want busy=1 in_count=1", st); end
    wb_wr(5'd0, 32'h2);
    wb_rd(5'd1, st);
    checks++; if (st[12:8] !== 5'd0 || st[0] !== 1'b1) begin failures++; $display("FAIL flush_in got=%h want in_count=0 busy=1", st); end
    stall = 1'b0;
    wait_cyc(30);
    wb_rd(5'd1, st);
    checks++; if (st[0] !== 1'b0 || st[4] !== 1'b0 || st[20:16] !== 5'd0) begin failures++; $display("FAIL flush_post got=%h want busy=0 done=0 out=0", st); end
    checks++; if (n_start - base != 1) begin failures++; $display("FAIL flush_starts got=%0d want=1", n_start - base); end
  endtask

`ifdef AES_WB_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] st; logic hit;
    wb_wr(5'd1, 32'h38);
    wb_wr(5'd0, 32'h4);
    stall = 1'b1;
    wb_wr(5'd0, 32'h5);
    wb_rd(5'd1, st);
    checks++; if (st[5] !== 1'b0 || st[0] !== 1'b1) begin failures++; $display("FAIL tmo_early got=%h want tmo=0 busy=1", st); end
    poll_status(32'h20, 40, st, hit);
    checks++; if (hit !== 1'b1 || st[0] !== 1'b0) begin failures++; $display("FAIL tmo_set got=%h want tmo=1 busy=0", st); end
    wait_cyc(2);
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL tmo_irq got=%b want=1", int_o); end
    wb_wr(5'd1, 32'h20);
    wb_wr(5'd0, 32'h0);
  endtask
`endif

  task automatic test_reset_mid_wait;
    logic [31:0] st;
    stall = 1'b1;
    wb_wr(5'd0, 32'h1);
    wait_cyc(4);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (core_key !== '0) begin failures++; $display("FAIL rstw_key got=%h want=0", core_key); end
    checks++; if (core_state !== '0) begin failures++; $display("FAIL rstw_state got=%h want=0", core_state); end
    checks++; if (int_o !== 1'b0 || core_start !== 1'b0) begin failures++; $display("FAIL rstw_ctl int=%b start=%b want 0", int_o, core_start); end
    checks++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin failures++; $display("FAIL rstw_bus ack=%b err=%b want 0", bus.wb_ack_o, bus.wb_err_o); end
    wait_cyc(2);
    rst = 1'b0;
    stall = 1'b0;
    wb_rd(5'd1, st);
    checks++; if (st !== 32'h0) begin failures++; $display("FAIL rstw_status got=%h want=0", st); end
    wb_rd(5'd6, st);
    checks++; if (st !== 32'h0) begin failures++; $display("FAIL rstw_keyreg got=%h want=0", st); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queue_full();
    test_flush();
`ifdef AES_WB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
